wbuf_fill: RTL and testbench
============================

# wbuf_fill

Weight buffer fill stage directly downstream of the weight-send sequencer. Captures SRAM read data into one of NCOL weight columns, selected by the sequencer's column select, while the sequencer holds the buffer enable and asserts the SRAM read strobe. Per-column write pointers track fill level and report full/overflow. A registered random-access read port serves the PE array.

## Interface
Parameters:
- DW, 16, weight word width (SRAM read data width)
- NCOL, 64, number of weight columns (matches 6-bit column select)
- DEPTH, 8, words per column; power of two, ≥2

Ports:
- CLK  in  1  clock, all logic on rising edge
- RSTL  in  1  reset; synchronous, active-low
- WBUF_EN  in  1  buffer accept enable from sequencer
- WBUF_EN_CTRL  in  6  target column index
- RCEBX  in  1  SRAM read strobe, active-low; read issued this cycle
- RDATA  in  DW  SRAM read data, valid exactly 1 cycle after RCEBX=0
- WBUF_CLR  in  1  clear all column pointers, full flags, overflow
- RD_COL  in  6  PE read column
- RD_IDX  in  log2(DEPTH)  PE read word index
- RD_DATA  out  DW  registered read data
- COL_FULL  out  NCOL  per-column full flag
- ALL_FULL  out  1  AND of COL_FULL
- OVF  out  1  sticky overflow error

## Operation
- Capture qualifier: cap = WBUF_EN & ~RCEBX & (WBUF_EN_CTRL < NCOL). Registered with column into pend_v/pend_col.
- Cycle after cap: if pend_v, write RDATA to mem[pend_col][wptr[pend_col]], then wptr[pend_col] += 1.
- wptr per column is log2(DEPTH)+1 bits. COL_FULL[c] = (wptr[c] == DEPTH). No wrap-around.
- Write into a full column: data dropped, wptr unchanged, OVF set. OVF stays set until WBUF_CLR or reset.
- Column select ≥ NCOL (NCOL<64 builds only): capture ignored, OVF set.
- WBUF_CLR: next edge sets all wptr=0, COL_FULL=0, OVF=0, pend_v=0. Overrides any same-cycle write or pend. Memory contents retained.
- WBUF_EN=1 with RCEBX=1: nothing captured. Matches the sequencer's address-setup cycles.
- Read port: RD_DATA <= mem[RD_COL][RD_IDX] every cycle, unconditionally. A read of an unwritten slot returns stale contents, not an error.
- Same-cycle read and write of the same slot: RD_DATA returns old data (read-before-write).
- Reset: RD_DATA=0, COL_FULL=0, ALL_FULL=0, OVF=0, pend_v=0, all wptr=0. Memory not reset.
- Reset asserted mid-fill: pending capture discarded. The RDATA word arriving after release is not written.

## Timing
- Cycle t: WBUF_EN=1, RCEBX=0, WBUF_EN_CTRL=c.
- Cycle t+1: RDATA sampled and written at the end-of-cycle edge.
- Cycle t+2: wptr/COL_FULL/OVF reflect the write. Fill latency is 2 cycles from strobe to flag.
- Back-to-back strobes every cycle are supported, one word per cycle, including alternating columns.
- Read latency: 1 cycle from RD_COL/RD_IDX to RD_DATA. A read at t+2 sees a word written at t+1.
- ALL_FULL is combinational from registered COL_FULL; no extra latency.

## Structure
- Shared package wbuf_pkg: DW, NCOL, DEPTH, COL_W=6, IDX_W=log2(DEPTH), PTR_W=IDX_W+1. The sequencer uses the same package.
- Sub-module wbuf_col, instantiated NCOL times via generate. Contents: DEPTH×DW storage, wptr, full flag, write enable, read mux.
- Top level holds the capture pipeline register, column decode, OVF logic, and the NCOL:1 read mux plus RD_DATA register.

## Test plan
- Reset, then fill column 0 with 8 strobes, RDATA=0x100..0x107 → COL_FULL[0]=1 at 2 cycles after the last strobe. Reads idx 0..7 return 0x100..0x107. OVF=0.
- 9th strobe to full column 0 with RDATA=0xDEAD → OVF=1, mem[0][7] still 0x107, wptr unchanged.
- Alternate strobes to columns 5 and 63 every cycle, 16 total → both COL_FULL set, each holds its own 8 words in order, other columns empty.
- WBUF_CLR in the same cycle a pending write lands → no write, all COL_FULL=0, OVF=0. Next fill of that column starts at idx 0.
- WBUF_EN=1 with RCEBX=1 for 4 cycles → no pointer movement. WBUF_EN=0 with RCEBX=0 → no capture.
- RSTL=0 for 1 cycle between strobe and data → data dropped, all outputs 0. Fill all 64 columns → ALL_FULL=1.

Source files
------------

// File: rtl/wbuf_pkg.sv
// Shared sizing and types for the weight buffer and the weight-send sequencer.
// Column select is fixed at 6 bits; NCOL may be smaller, in which case high selects are rejected.
package wbuf_pkg;
    localparam int DW    = 16;
    localparam int NCOL  = 64;
    localparam int DEPTH = 8;
    localparam int COL_W = 6;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic             v;
        logic [COL_W-1:0] col;
    } pend_t;

    function automatic logic col_ok(input logic [COL_W-1:0] col);
        return ({1'b0, col} < (COL_W+1)'(NCOL));
    endfunction
endpackage

// File: rtl/wbuf_col.sv
// One weight column: DEPTH-word store, fill pointer and full flag, plus an asynchronous word select
// that the top level registers.
module wbuf_col
    import wbuf_pkg::*;
(
    input  logic             clk,
    input  logic             rstl,
    input  logic             clr,
    input  logic             we,
    input  logic [DW-1:0]    wdata,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [DW-1:0]    rd_word,
    output logic             full
);
    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wptr_reg;
    logic             wr_ok;

    assign full    = (wptr_reg == PTR_W'(DEPTH));
    assign wr_ok   = we && !full;
    assign rd_word = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rstl) begin
            wptr_reg <= '0;
        end else if (clr) begin
            wptr_reg <= '0;
        end else if (wr_ok) begin
            wptr_reg <= wptr_reg + 1'b1;
        end
    end

    // Storage is deliberately not reset; the pointer alone defines what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr_reg[IDX_W-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/wbuf_fill.sv
// Weight buffer fill stage: registers the sequencer's capture strobe, lands the SRAM word one cycle
// later into the selected column, tracks overflow and serves a registered random-access read.
module wbuf_fill
    import wbuf_pkg::*;
(
    input  logic             CLK,
    input  logic             RSTL,
    input  logic             WBUF_EN,
    input  logic [COL_W-1:0] WBUF_EN_CTRL,
    input  logic             RCEBX,
    input  logic [DW-1:0]    RDATA,
    input  logic             WBUF_CLR,
    input  logic [COL_W-1:0] RD_COL,
    input  logic [IDX_W-1:0] RD_IDX,
    output logic [DW-1:0]    RD_DATA,
    output logic [NCOL-1:0]  COL_FULL,
    output logic             ALL_FULL,
    output logic             OVF
);
    pend_t         pend_reg;
    logic          ovf_reg;
    logic          strobe;
    logic          cap;
    logic          bad_sel;
    logic          wr_live;
    logic          full_hit;
    logic [DW-1:0] rd_words [NCOL];

    assign strobe  = WBUF_EN & ~RCEBX;
    assign cap     = strobe & col_ok(WBUF_EN_CTRL);
    assign bad_sel = strobe & ~col_ok(WBUF_EN_CTRL);

    // A clear or reset in the landing cycle kills the pending write outright.
    assign wr_live  = pend_reg.v & ~WBUF_CLR & RSTL;
    assign full_hit = wr_live & COL_FULL[pend_reg.col];

    always_ff @(posedge CLK) begin
        if (!RSTL) begin
            pend_reg <= '0;
            ovf_reg  <= 1'b0;
        end else if (WBUF_CLR) begin
            pend_reg <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            pend_reg.v   <= cap;
            pend_reg.col <= WBUF_EN_CTRL;
            if (full_hit || bad_sel) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCOL; gi++) begin : g_col
            wbuf_col u_col (
                .clk     (CLK),
                .rstl    (RSTL),
                .clr     (WBUF_CLR),
                .we      (wr_live && (pend_reg.col == COL_W'(gi))),
                .wdata   (RDATA),
                .rd_idx  (RD_IDX),
                .rd_word (rd_words[gi]),
                .full    (COL_FULL[gi])
            );
        end
    endgenerate

    // Column storage is read before this edge's write, so a same-slot read returns old data.
    always_ff @(posedge CLK) begin
        if (!RSTL) begin
            RD_DATA <= '0;
        end else if (col_ok(RD_COL)) begin
            RD_DATA <= rd_words[RD_COL];
        end else begin
            RD_DATA <= '0;
        end
    end

    assign ALL_FULL = &COL_FULL;
    assign OVF      = ovf_reg;
endmodule

// File: tb/tb_wbuf_fill.sv
// Self-checking bench for wbuf_fill: directed fill/overflow/clear/reset sequences, table-driven
// read-back, and randomized traffic against a per-column fill model.
module tb_wbuf_fill;
    localparam int NC = 64;
    localparam int DP = 8;

    logic        CLK = 1'b0;
    logic        RSTL;
    logic        WBUF_EN;
    logic [5:0]  WBUF_EN_CTRL;
    logic        RCEBX;
    logic [15:0] RDATA;
    logic        WBUF_CLR;
    logic [5:0]  RD_COL;
    logic [2:0]  RD_IDX;
    logic [15:0] RD_DATA;
    logic [63:0] COL_FULL;
    logic        ALL_FULL;
    logic        OVF;

    int checks   = 0;
    int failures = 0;

    // Reference model: word store with known-flags, per-column fill count, sticky error, one-deep capture.
    logic [15:0] m_mem   [NC][DP];
    bit          m_known [NC][DP];
    int          m_cnt   [NC];
    bit          m_ovf;
    bit          m_pv;
    int          m_pc;
    logic [15:0] m_rd;
    bit          m_rd_known;

    typedef struct {
        int          col;
        int          idx;
        logic [15:0] exp;
    } rd_vec_t;
    rd_vec_t vt[$];

    wbuf_fill dut (
        .CLK          (CLK),
        .RSTL         (RSTL),
        .WBUF_EN      (WBUF_EN),
        .WBUF_EN_CTRL (WBUF_EN_CTRL),
        .RCEBX        (RCEBX),
        .RDATA        (RDATA),
        .WBUF_CLR     (WBUF_CLR),
        .RD_COL       (RD_COL),
        .RD_IDX       (RD_IDX),
        .RD_DATA      (RD_DATA),
        .COL_FULL     (COL_FULL),
        .ALL_FULL     (ALL_FULL),
        .OVF          (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        if (!RSTL) begin
            for (int c = 0; c < NC; c++) m_cnt[c] = 0;
            m_ovf = 0; m_pv = 0; m_rd = '0; m_rd_known = 1;
            return;
        end
        m_rd       = m_mem[RD_COL][RD_IDX];
        m_rd_known = m_known[RD_COL][RD_IDX];
        if (WBUF_CLR) begin
            for (int c = 0; c < NC; c++) m_cnt[c] = 0;
            m_ovf = 0; m_pv = 0;
            return;
        end
        if (m_pv) begin
            if (m_cnt[m_pc] == DP) begin
                m_ovf = 1;
            end else begin
                m_mem[m_pc][m_cnt[m_pc]]   = RDATA;
                m_known[m_pc][m_cnt[m_pc]] = 1;
                m_cnt[m_pc]++;
            end
        end
        m_pv = WBUF_EN && !RCEBX;
        m_pc = int'(WBUF_EN_CTRL);
    endfunction

    task automatic check_all();
        logic [63:0] ef;
        for (int c = 0; c < NC; c++) ef[c] = (m_cnt[c] == DP);
        chk("col_full", COL_FULL, ef);
        chk("all_full", {63'd0, ALL_FULL}, {63'd0, &ef});
        chk("ovf", {63'd0, OVF}, {63'd0, m_ovf});
        if (m_rd_known) chk("rd_data", {48'd0, RD_DATA}, {48'd0, m_rd});
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic drive(input bit en, input bit rcebx, input int col, input logic [15:0] d);
        WBUF_EN      = en;
        RCEBX        = rcebx;
        WBUF_EN_CTRL = 6'(col);
        RDATA        = d;
        tick();
    endtask

    task automatic run_table();
        foreach (vt[i]) begin
            WBUF_EN = 0; RCEBX = 1;
            RD_COL  = 6'(vt[i].col);
            RD_IDX  = 3'(vt[i].idx);
            tick();
            chk("tbl_rd", {48'd0, RD_DATA}, {48'd0, vt[i].exp});
            $display("read col=%0d idx=%0d data=0x%0h exp=0x%0h", vt[i].col, vt[i].idx, RD_DATA, vt[i].exp);
        end
        vt.delete();
    endtask

    initial begin
        for (int c = 0; c < NC; c++) begin
            m_cnt[c] = 0;
            for (int i = 0; i < DP; i++) m_known[c][i] = 0;
        end
        RSTL = 0; WBUF_EN = 0; WBUF_EN_CTRL = 0; RCEBX = 1; RDATA = 0;
        WBUF_CLR = 0; RD_COL = 0; RD_IDX = 0;
        tick();
        tick();
        chk("rst_rd", {48'd0, RD_DATA}, 64'd0);
        chk("rst_full", COL_FULL, 64'd0);
        chk("rst_ovf", {63'd0, OVF}, 64'd0);
        RSTL = 1;
        tick();

        // Fill column 0; full flag appears two cycles after the last strobe.
        for (int i = 0; i <= 8; i++) begin
            drive(i < 8, !(i < 8), 0, 16'(16'h100 + i - 1));
            if (i == 7) chk("fill_full_early", {63'd0, COL_FULL[0]}, 64'd0);
            if (i == 8) chk("fill_full", {63'd0, COL_FULL[0]}, 64'd1);
        end
        $display("fill col0 done full=%0b ovf=%0b", COL_FULL[0], OVF);
        for (int i = 0; i < 8; i++) vt.push_back('{0, i, 16'(16'h100 + i)});
        run_table();
        chk("fill_ovf", {63'd0, OVF}, 64'd0);

        // Overflow into a full column.
        drive(1, 0, 0, 16'h0);
        drive(0, 1, 0, 16'hDEAD);
        chk("ovf_set", {63'd0, OVF}, 64'd1);
        chk("ovf_full_kept", {63'd0, COL_FULL[0]}, 64'd1);
        vt.push_back('{0, 7, 16'h107});
        run_table();

        // Alternating columns 5 and 63, back-to-back.
        for (int k = 0; k <= 16; k++) begin
            logic [15:0] d;
            d = ((k - 1) % 2 == 0) ? 16'(16'h500 + (k - 1) / 2) : 16'(16'h3F00 + (k - 1) / 2);
            drive(k < 16, !(k < 16), (k % 2 == 0) ? 5 : 63, d);
        end
        drive(0, 1, 0, 16'h0);
        chk("alt_full5", {63'd0, COL_FULL[5]}, 64'd1);
        chk("alt_full63", {63'd0, COL_FULL[63]}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            vt.push_back('{5, i, 16'(16'h500 + i)});
            vt.push_back('{63, i, 16'(16'h3F00 + i)});
        end
        run_table();

        // Clear lands in the same cycle as a pending write.
        drive(1, 0, 1, 16'h0);
        WBUF_CLR = 1;
        drive(0, 1, 0, 16'hBEEF);
        WBUF_CLR = 0;
        chk("clr_full", COL_FULL, 64'd0);
        chk("clr_ovf", {63'd0, OVF}, 64'd0);
        drive(1, 0, 1, 16'h0);
        drive(0, 1, 0, 16'hAAAA);
        vt.push_back('{1, 0, 16'hAAAA});
        run_table();

        // Address-setup cycles and enable-low strobes must not capture.
        for (int i = 0; i < 4; i++) drive(1, 1, 2, 16'(16'h2000 + i));
        drive(0, 0, 2, 16'h2100);
        drive(0, 0, 2, 16'h2101);
        drive(1, 0, 2, 16'h0);
        drive(0, 1, 0, 16'h2222);
        vt.push_back('{2, 0, 16'h2222});
        run_table();

        // Reset between strobe and data: the arriving word must not be written.
        drive(1, 0, 3, 16'h0);
        drive(1, 0, 3, 16'h3000);
        drive(0, 1, 0, 16'h3001);
        WBUF_CLR = 1;
        drive(0, 1, 0, 16'h0);
        WBUF_CLR = 0;
        drive(1, 0, 3, 16'h0);
        RSTL = 0;
        drive(0, 1, 0, 16'h3333);
        chk("rst_mid_rd", {48'd0, RD_DATA}, 64'd0);
        chk("rst_mid_full", COL_FULL, 64'd0);
        chk("rst_mid_ovf", {63'd0, OVF}, 64'd0);
        chk("rst_mid_all", {63'd0, ALL_FULL}, 64'd0);
        RSTL = 1;
        drive(0, 1, 0, 16'h3334);
        vt.push_back('{3, 0, 16'h3000});
        vt.push_back('{3, 1, 16'h3001});
        run_table();

        // Fill every column.
        for (int k = 0; k <= NC * DP; k++) begin
            drive(k < NC * DP, !(k < NC * DP), k / DP, 16'(16'h8000 + k - 1));
            if (k == NC * DP - 1) chk("all_full_early", {63'd0, ALL_FULL}, 64'd0);
            if (k == NC * DP) chk("all_full", {63'd0, ALL_FULL}, 64'd1);
        end
        $display("fill all done all_full=%0b", ALL_FULL);

        // Randomized traffic against the model.
        WBUF_CLR = 1;
        drive(0, 1, 0, 16'h0);
        WBUF_CLR = 0;
        for (int n = 0; n < 1200; n++) begin
            RSTL     = ($urandom_range(0, 99) != 0);
            WBUF_CLR = ($urandom_range(0, 59) == 0);
            RD_COL   = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
            RD_IDX   = 3'($urandom_range(0, 7));
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4,
                  ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 7)),
                  16'($urandom));
        end
        $display("random phase done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
